// File: rtl/battle_round_timer_pkg.sv
// Shared definitions for the battle round timer: FSM states and parameter defaults.
package battle_round_timer_pkg;

   localparam int unsigned CLK_HZ_DEFAULT    = 50_000_000;
   localparam int unsigned ROUND_SEC_DEFAULT = 60;
   localparam int unsigned WARN_SEC_DEFAULT  = 10;
   localparam int unsigned SEC_W_DEFAULT     = 8;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StPaused,
      StExpired
   } state_e;

endpackage

// File: rtl/battle_round_timer_sec_prescaler.sv
// Seconds prescaler: counts enabled cycles 0..CLK_HZ-1 and flags the terminal count.
// tick is combinational so the owner can register it together with its own state.
module sec_prescaler #(
   parameter int unsigned CLK_HZ = battle_round_timer_pkg::CLK_HZ_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int unsigned CNT_W = $clog2(CLK_HZ);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);

   if (CLK_HZ < 2) begin : g_bad_clk_hz
      $error("sec_prescaler: CLK_HZ must be >= 2");
   end

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Terminal count only counts as a tick on an enabled, non-cleared edge
   assign tick = en & ~clr & (cnt_q == LAST);

   // Next count: clear wins, otherwise advance and wrap while enabled
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   // Count register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/battle_round_timer.sv
// Battle round countdown timer with pause, warning window and sticky expiry flag.
module battle_round_timer
   import battle_round_timer_pkg::*;
#(
   parameter int unsigned CLK_HZ    = CLK_HZ_DEFAULT,
   parameter int unsigned ROUND_SEC = ROUND_SEC_DEFAULT,
   parameter int unsigned WARN_SEC  = WARN_SEC_DEFAULT,
   parameter int unsigned SEC_W     = SEC_W_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             battle,
   input  logic             pause,
   input  logic             restart,
   output logic             sec_tick,
   output logic [SEC_W-1:0] sec_left,
   output logic             warning,
   output logic             timer,
   output logic             expired_pulse
);

   if (SEC_W < 1 || SEC_W > 31) begin : g_bad_sec_w
      $error("battle_round_timer: SEC_W must be 1..31");
   end
   if (ROUND_SEC < 1 || (ROUND_SEC >> SEC_W) != 0) begin : g_bad_round_sec
      $error("battle_round_timer: ROUND_SEC must be 1..2^SEC_W-1");
   end
   if (WARN_SEC > ROUND_SEC) begin : g_bad_warn_sec
      $error("battle_round_timer: WARN_SEC must be <= ROUND_SEC");
   end

   localparam logic [SEC_W-1:0] ROUND_V = SEC_W'(ROUND_SEC);
   localparam logic [SEC_W-1:0] WARN_V  = SEC_W'(WARN_SEC);
   localparam logic [SEC_W-1:0] ONE     = SEC_W'(1);

   state_e           state_q, state_d;
   logic [SEC_W-1:0] sec_left_q, sec_left_d;
   logic             sec_tick_q, sec_tick_d;
   logic             warning_q, warning_d;
   logic             timer_q, timer_d;
   logic             pulse_q, pulse_d;

   logic go;
   logic pre_clr;
   logic pre_en;
   logic pre_tick;

   assign go      = battle & ~pause;
   // Prescaler is held at zero in IDLE so every round starts on a fresh second
   assign pre_clr = restart | (state_q == StIdle);
   // Counting happens on every go edge once the round is live, including the edge
   // that leaves PAUSED, so each held cycle delays expiry by exactly one cycle
   assign pre_en  = go & ~restart & ((state_q == StRun) | (state_q == StPaused));

   sec_prescaler #(
      .CLK_HZ(CLK_HZ)
   ) u_sec_prescaler (
      .clk  (clk),
      .reset(reset),
      .clr  (pre_clr),
      .en   (pre_en),
      .tick (pre_tick)
   );

   // Next-state and registered-output logic; restart overrides everything
   always_comb begin
      state_d    = state_q;
      sec_left_d = sec_left_q;
      timer_d    = timer_q;
      sec_tick_d = 1'b0;
      pulse_d    = 1'b0;

      if (restart) begin
         state_d    = StIdle;
         sec_left_d = ROUND_V;
         timer_d    = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               sec_left_d = ROUND_V;
               if (go) state_d = StRun;
            end
            StRun, StPaused: begin
               state_d = go ? StRun : StPaused;
               if (pre_tick) begin
                  sec_tick_d = 1'b1;
                  if (sec_left_q <= ONE) begin
                     sec_left_d = '0;
                     state_d    = StExpired;
                     timer_d    = 1'b1;
                     pulse_d    = 1'b1;
                  end else begin
                     sec_left_d = sec_left_q - ONE;
                  end
               end
            end
            StExpired: begin
               sec_left_d = '0;
               timer_d    = 1'b1;
            end
            default: begin
               state_d    = StIdle;
               sec_left_d = ROUND_V;
               timer_d    = 1'b0;
            end
         endcase
      end

      // Computed from next values so the registered flag lines up with sec_left
      warning_d = ((state_d == StRun) || (state_d == StPaused)) &&
                  (sec_left_d != '0) && (sec_left_d <= WARN_V);
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         sec_left_q <= ROUND_V;
         sec_tick_q <= 1'b0;
         warning_q  <= 1'b0;
         timer_q    <= 1'b0;
         pulse_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         sec_left_q <= sec_left_d;
         sec_tick_q <= sec_tick_d;
         warning_q  <= warning_d;
         timer_q    <= timer_d;
         pulse_q    <= pulse_d;
      end
   end

   assign sec_tick      = sec_tick_q;
   assign sec_left      = sec_left_q;
   assign warning       = warning_q;
   assign timer         = timer_q;
   assign expired_pulse = pulse_q;

endmodule

// File: tb/tb_battle_round_timer.sv
// Self-checking bench for battle_round_timer with a small elapsed-cycle reference model.
module tb_battle_round_timer;

   localparam int unsigned CLK_HZ    = 4;
   localparam int unsigned ROUND_SEC = 3;
   localparam int unsigned WARN_SEC  = 1;
   localparam int unsigned SEC_W     = 8;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             battle = 1'b0;
   logic             pause = 1'b0;
   logic             restart = 1'b0;
   logic             sec_tick;
   logic [SEC_W-1:0] sec_left;
   logic             warning;
   logic             timer;
   logic             expired_pulse;

   int checks = 0;
   int errors = 0;

   battle_round_timer #(
      .CLK_HZ   (CLK_HZ),
      .ROUND_SEC(ROUND_SEC),
      .WARN_SEC (WARN_SEC),
      .SEC_W    (SEC_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .battle       (battle),
      .pause        (pause),
      .restart      (restart),
      .sec_tick     (sec_tick),
      .sec_left     (sec_left),
      .warning      (warning),
      .timer        (timer),
      .expired_pulse(expired_pulse)
   );

   always #5 clk = ~clk;

   // Reference model: a round is a count of elapsed counting cycles
   bit m_started;
   bit m_expired;
   int m_ran;
   bit m_tick;
   bit m_pulse;

   function automatic void mdl_reset();
      m_started = 0;
      m_expired = 0;
      m_ran     = 0;
      m_tick    = 0;
      m_pulse   = 0;
   endfunction

   function automatic void mdl_edge(input bit b, input bit p, input bit r);
      m_tick  = 0;
      m_pulse = 0;
      if (r) begin
         m_started = 0;
         m_expired = 0;
         m_ran     = 0;
      end else if (!m_expired) begin
         if (!m_started) begin
            if (b && !p) m_started = 1;
         end else if (b && !p) begin
            m_ran++;
            if (m_ran % CLK_HZ == 0) m_tick = 1;
            if (m_ran == ROUND_SEC * CLK_HZ) begin
               m_expired = 1;
               m_pulse   = 1;
            end
         end
      end
   endfunction

   function automatic int mdl_left();
      if (m_expired) return 0;
      return ROUND_SEC - m_ran / CLK_HZ;
   endfunction

   function automatic int mdl_warn();
      int l;
      l = mdl_left();
      return (m_started && !m_expired && l > 0 && l <= WARN_SEC) ? 1 : 0;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cmp_model(input string tag);
      chk({tag, " sec_left"}, int'(sec_left), mdl_left());
      chk({tag, " sec_tick"}, int'(sec_tick), int'(m_tick));
      chk({tag, " warning"}, int'(warning), mdl_warn());
      chk({tag, " timer"}, int'(timer), int'(m_expired));
      chk({tag, " expired_pulse"}, int'(expired_pulse), int'(m_pulse));
   endtask

   // Drive inputs at the falling edge, clock once, return at the next falling edge
   task automatic step(input bit b, input bit p, input bit r);
      battle  = b;
      pause   = p;
      restart = r;
      @(posedge clk);
      mdl_edge(b, p, r);
      @(negedge clk);
   endtask

   task automatic do_reset();
      battle  = 0;
      pause   = 0;
      restart = 0;
      reset   = 0;
      @(negedge clk);
      @(negedge clk);
      reset = 1;
      mdl_reset();
   endtask

   // Steps with battle held until expired_pulse; n = steps taken, 0 on timeout
   task automatic run_to_expiry(output int n);
      n = 0;
      for (int i = 1; i <= 40; i++) begin
         step(1, 0, 0);
         if (expired_pulse) begin
            n = i;
            break;
         end
      end
   endtask

   typedef struct {
      bit battle;
      bit pause;
      bit restart;
      int left;
      bit tick;
      bit warn;
      bit tmr;
      bit pulse;
   } vec_t;

   vec_t vecs[16];

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int n;
      bit b, p, r;

      // Edge-by-edge expectations for a full round with battle held, then restart
      vecs[0]  = '{1, 0, 0, 3, 0, 0, 0, 0};
      vecs[1]  = '{1, 0, 0, 3, 0, 0, 0, 0};
      vecs[2]  = '{1, 0, 0, 3, 0, 0, 0, 0};
      vecs[3]  = '{1, 0, 0, 3, 0, 0, 0, 0};
      vecs[4]  = '{1, 0, 0, 2, 1, 0, 0, 0};
      vecs[5]  = '{1, 0, 0, 2, 0, 0, 0, 0};
      vecs[6]  = '{1, 0, 0, 2, 0, 0, 0, 0};
      vecs[7]  = '{1, 0, 0, 2, 0, 0, 0, 0};
      vecs[8]  = '{1, 0, 0, 1, 1, 1, 0, 0};
      vecs[9]  = '{1, 0, 0, 1, 0, 1, 0, 0};
      vecs[10] = '{1, 0, 0, 1, 0, 1, 0, 0};
      vecs[11] = '{1, 0, 0, 1, 0, 1, 0, 0};
      vecs[12] = '{1, 0, 0, 0, 1, 0, 1, 1};
      vecs[13] = '{1, 0, 0, 0, 0, 0, 1, 0};
      vecs[14] = '{1, 0, 1, 3, 0, 0, 0, 0};
      vecs[15] = '{1, 0, 0, 3, 0, 0, 0, 0};

      mdl_reset();
      reset = 0;
      @(negedge clk);
      chk("reset sec_left", int'(sec_left), 3);
      chk("reset sec_tick", int'(sec_tick), 0);
      chk("reset warning", int'(warning), 0);
      chk("reset timer", int'(timer), 0);
      chk("reset expired_pulse", int'(expired_pulse), 0);
      @(negedge clk);
      reset = 1;

      // Table-driven full round
      for (int i = 0; i < 16; i++) begin
         step(vecs[i].battle, vecs[i].pause, vecs[i].restart);
         chk($sformatf("vec%0d sec_left", i), int'(sec_left), vecs[i].left);
         chk($sformatf("vec%0d sec_tick", i), int'(sec_tick), int'(vecs[i].tick));
         chk($sformatf("vec%0d warning", i), int'(warning), int'(vecs[i].warn));
         chk($sformatf("vec%0d timer", i), int'(timer), int'(vecs[i].tmr));
         chk($sformatf("vec%0d expired_pulse", i), int'(expired_pulse), int'(vecs[i].pulse));
      end

      // Pause for 10 cycles after 6 counting cycles: sec_left frozen, expiry delayed
      do_reset();
      for (int i = 0; i < 7; i++) step(1, 0, 0);
      chk("pause pre sec_left", int'(sec_left), 2);
      for (int i = 0; i < 10; i++) begin
         step(1, 1, 0);
         chk($sformatf("pause%0d sec_left", i), int'(sec_left), 2);
         chk($sformatf("pause%0d sec_tick", i), int'(sec_tick), 0);
      end
      run_to_expiry(n);
      chk("pause resume steps to expiry", n, 6);
      chk("pause expiry timer", int'(timer), 1);

      // In EXPIRED, battle and pause are ignored
      for (int i = 0; i < 20; i++) begin
         b = 1'($urandom_range(0, 1));
         p = 1'($urandom_range(0, 1));
         step(b, p, 0);
         chk($sformatf("expired%0d timer", i), int'(timer), 1);
         chk($sformatf("expired%0d sec_left", i), int'(sec_left), 0);
         chk($sformatf("expired%0d sec_tick", i), int'(sec_tick) | int'(expired_pulse), 0);
      end

      // Restart on the terminal-count edge of the last second
      do_reset();
      for (int i = 0; i < 12; i++) step(1, 0, 0);
      chk("term pre sec_left", int'(sec_left), 1);
      step(1, 0, 1);
      chk("term restart expired_pulse", int'(expired_pulse), 0);
      chk("term restart sec_tick", int'(sec_tick), 0);
      chk("term restart timer", int'(timer), 0);
      chk("term restart sec_left", int'(sec_left), 3);
      chk("term restart warning", int'(warning), 0);
      run_to_expiry(n);
      chk("term restart fresh round steps", n, 13);

      // Asynchronous reset mid-round
      do_reset();
      for (int i = 0; i < 6; i++) step(1, 0, 0);
      chk("async pre sec_left", int'(sec_left), 2);
      #1 reset = 0;
      #1;
      chk("async sec_left", int'(sec_left), 3);
      chk("async sec_tick", int'(sec_tick), 0);
      chk("async warning", int'(warning), 0);
      chk("async timer", int'(timer), 0);
      chk("async expired_pulse", int'(expired_pulse), 0);
      @(negedge clk);
      reset = 1;
      mdl_reset();
      run_to_expiry(n);
      chk("async fresh round steps", n, 13);

      // Randomized run against the reference model
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         r = ($urandom_range(0, 63) == 0);
         b = ($urandom_range(0, 9) != 0);
         p = ($urandom_range(0, 7) == 0);
         step(b, p, r);
         cmp_model($sformatf("rand%0d", i));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
